// File: rtl/lcd_pkg.sv
// HD44780 command constants and FSM state types shared by the LCD text controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_pkg;

  // HD44780 instruction bytes
  localparam logic [7:0] FUNC_SET_8B = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] FUNC_SET_4B = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] DISP_ON     = 8'h0C;  // display on, cursor off, blink off
  localparam logic [7:0] ENTRY_INC   = 8'h06;  // auto-increment, no shift
  localparam logic [7:0] CLEAR       = 8'h01;  // clear display (long execution time)
  localparam logic [7:0] SET_DDRAM   = 8'h80;  // set DDRAM address
  localparam logic [7:0] LINE1_BASE  = 8'h40;  // DDRAM base of the second line
  localparam logic [7:0] CHAR_SPACE  = 8'h20;  // blank cell written by the clear sweep

  // Main sequencing FSM
  typedef enum logic [1:0] {
    M_PWRUP,
    M_INIT,
    M_LINE_SEL,
    M_CHAR
  } main_state_t;

  // Per-transfer bus timing FSM (IDLE only during power-up)
  typedef enum logic [2:0] {
    B_IDLE,
    B_SETUP,
    B_PULSE,
    B_HOLD,
    B_WAIT
  } byte_state_t;

  // DDRAM address command for the start of a line
  function automatic logic [7:0] line_sel_cmd(input logic line1);
    return SET_DDRAM | (line1 ? LINE1_BASE : 8'h00);
  endfunction

endpackage

// File: rtl/lcd_text_buf.sv
// Character buffer: DEPTH x 8 simple dual-port RAM, sync write, registered read, clear sweep.
// Latency: read data valid 1 clock after i_rd_addr; writes visible to reads issued after the write clock.
// Backpressure: none; while i_clr is high the sweep writes one blank per clock and user writes lose.
//
// Ports: i_clk/i_rst (sync, active high), i_clr (sweep enable, restarts when deasserted),
//        i_wr_en/i_wr_addr/i_wr_data (user write), i_rd_addr/o_rd_data (registered read).
module lcd_text_buf
  import lcd_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  logic [7:0]    r_mem [DEPTH];
  logic [7:0]    r_rd_data;
  logic [AW-1:0] r_clr_idx;
  logic          r_clr_done;
  logic          w_clr_wr;

  assign w_clr_wr  = i_clr && !r_clr_done && !i_rst;
  assign o_rd_data = r_rd_data;

  // Sweep pointer: runs once per assertion of i_clr, then parks
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_clr) begin
      r_clr_idx  <= '0;
      r_clr_done <= 1'b0;
    end else if (!r_clr_done) begin
      if (r_clr_idx == AW'(DEPTH - 1)) r_clr_done <= 1'b1;
      else                             r_clr_idx  <= r_clr_idx + 1'b1;
    end
  end

  // Read-before-write: a same-clock write to the read address returns the old byte
  always_ff @(posedge i_clk) begin
    if (w_clr_wr)     r_mem[r_clr_idx] <= CHAR_SPACE;
    else if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    r_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780 text controller: clears buffer, powers up, inits the panel, then refreshes LINES x COLS forever.
// Latency: first E rise PWRUP_WAIT_CYC+ENABLE_CYC clocks after reset; buffer writes show on the next refresh pass.
// Backpressure: writes accepted only while READY=1; out-of-range addresses are dropped silently.
//
// Ports: FPGA_CLK, RST (sync active high); WR_EN/WR_ADDR/WR_DATA buffer write port;
//        READY init done; LCD_RS/LCD_RW/LCD_E/LCD_D panel bus (RW always 0).
// Build option: define LCD_NIBBLE_MODE_EN for a 4-bit bus on LCD_D[7:4] (LCD_D[3:0] held 0).
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int COLS           = 16,
  parameter int LINES          = 2,
  parameter int ENABLE_CYC     = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLR_WAIT_CYC   = 100000,
  parameter int PWRUP_WAIT_CYC = 2000000
) (
  input  logic                           FPGA_CLK,
  input  logic                           RST,
  input  logic                           WR_EN,
  input  logic [$clog2(LINES*COLS)-1:0]  WR_ADDR,
  input  logic [7:0]                     WR_DATA,
  output logic                           READY,
  output logic                           LCD_RS,
  output logic                           LCD_RW,
  output logic                           LCD_E,
  output logic [7:0]                     LCD_D
);

  localparam int N     = LINES * COLS;
  localparam int AW    = $clog2(N);
  localparam int MAX_A = (PWRUP_WAIT_CYC > CLR_WAIT_CYC) ? PWRUP_WAIT_CYC : CLR_WAIT_CYC;
  localparam int MAX_B = (CMD_WAIT_CYC > ENABLE_CYC) ? CMD_WAIT_CYC : ENABLE_CYC;
  localparam int MAXW  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAXW + 1);
  localparam int CLW   = $clog2(COLS + 1);
`ifdef LCD_NIBBLE_MODE_EN
  localparam logic [2:0] INIT_LAST = 3'd7;
`else
  localparam logic [2:0] INIT_LAST = 3'd3;
`endif

  // Init script; in nibble mode the first four entries are lone high nibbles
  function automatic logic [7:0] init_byte(input logic [2:0] idx);
`ifdef LCD_NIBBLE_MODE_EN
    case (idx)
      3'd0, 3'd1, 3'd2: return 8'h30;
      3'd3:             return 8'h20;
      3'd4:             return FUNC_SET_4B;
      3'd5:             return DISP_ON;
      3'd6:             return ENTRY_INC;
      default:          return CLEAR;
    endcase
`else
    case (idx)
      3'd0:    return FUNC_SET_8B;
      3'd1:    return DISP_ON;
      3'd2:    return ENTRY_INC;
      default: return CLEAR;
    endcase
`endif
  endfunction

  main_state_t   r_main;
  byte_state_t   r_bst;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [CLW-1:0] r_col;
  logic          r_line;
  logic          r_is_clr;
  logic          r_ready;
  logic          r_rs;
  logic          r_e;
  logic [7:0]    r_d;
`ifdef LCD_NIBBLE_MODE_EN
  logic [7:0]    r_byte;
  logic          r_lo;
  logic          r_single;
  logic          w_nxt_single;
`endif

  main_state_t   w_nxt_main;
  logic [2:0]    w_nxt_idx;
  logic [CLW-1:0] w_nxt_col;
  logic          w_nxt_line;
  logic [7:0]    w_nxt_byte;
  logic          w_nxt_rs;
  logic          w_nxt_ready;
  logic          w_en_done;
  logic          w_launch;
  logic [CW-1:0] w_wait_end;
  logic [7:0]    w_rd_data;
  logic [AW-1:0] w_rd_addr;
  logic          w_wr_en;
  int            w_rd_idx;

  assign READY  = r_ready;
  assign LCD_RS = r_rs;
  assign LCD_RW = 1'b0;
  assign LCD_E  = r_e;
  assign LCD_D  = r_d;

  assign w_wr_en    = WR_EN && r_ready && (32'(WR_ADDR) < 32'(N));
  assign w_en_done  = (r_cnt == CW'(ENABLE_CYC - 1));
  assign w_wait_end = r_is_clr ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
  // A new transfer starts at the end of power-up or at the end of the previous byte's WAIT
  assign w_launch   = ((r_bst == B_IDLE) && (r_cnt == CW'(PWRUP_WAIT_CYC - 1))) ||
                      ((r_bst == B_WAIT) && (r_cnt == w_wait_end));

  // The buffer is read continuously at the address of the next data byte; that address
  // is stable for the whole current transfer, so the registered data is ready at launch.
  always_comb begin
    w_rd_idx = (r_line ? COLS : 0) + ((r_main == M_CHAR) ? int'(r_col) + 1 : 0);
    if (w_rd_idx >= N) w_rd_idx = 0;
    w_rd_addr = AW'(w_rd_idx);
  end

  lcd_text_buf #(
    .DEPTH (N),
    .AW    (AW)
  ) u_buf (
    .i_clk     (FPGA_CLK),
    .i_rst     (RST),
    .i_clr     (r_main == M_PWRUP),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (WR_ADDR),
    .i_wr_data (WR_DATA),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // What the next transfer is, given where the sequence currently stands
  always_comb begin
    w_nxt_main  = r_main;
    w_nxt_idx   = r_idx;
    w_nxt_col   = r_col;
    w_nxt_line  = r_line;
    w_nxt_byte  = 8'h00;
    w_nxt_rs    = 1'b0;
    w_nxt_ready = r_ready;
    case (r_main)
      M_PWRUP: begin
        w_nxt_main = M_INIT;
        w_nxt_idx  = 3'd0;
        w_nxt_byte = init_byte(3'd0);
      end
      M_INIT: begin
        if (r_idx == INIT_LAST) begin
          w_nxt_main  = M_LINE_SEL;
          w_nxt_line  = 1'b0;
          w_nxt_byte  = line_sel_cmd(1'b0);
          w_nxt_ready = 1'b1;
        end else begin
          w_nxt_idx  = r_idx + 3'd1;
          w_nxt_byte = init_byte(r_idx + 3'd1);
        end
      end
      M_LINE_SEL: begin
        w_nxt_main = M_CHAR;
        w_nxt_col  = '0;
        w_nxt_byte = w_rd_data;
        w_nxt_rs   = 1'b1;
      end
      M_CHAR: begin
        if (r_col == CLW'(COLS - 1)) begin
          w_nxt_main = M_LINE_SEL;
          w_nxt_line = (LINES > 1) ? ~r_line : 1'b0;
          w_nxt_byte = line_sel_cmd(w_nxt_line);
        end else begin
          w_nxt_col  = r_col + 1'b1;
          w_nxt_byte = w_rd_data;
          w_nxt_rs   = 1'b1;
        end
      end
      default: ;
    endcase
`ifdef LCD_NIBBLE_MODE_EN
    w_nxt_single = (w_nxt_main == M_INIT) && (w_nxt_idx < 3'd4);
`endif
  end

  always_ff @(posedge FPGA_CLK) begin
    if (RST) begin
      r_main   <= M_PWRUP;
      r_bst    <= B_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_col    <= '0;
      r_line   <= 1'b0;
      r_is_clr <= 1'b0;
      r_ready  <= 1'b0;
      r_rs     <= 1'b0;
      r_e      <= 1'b0;
      r_d      <= 8'h00;
`ifdef LCD_NIBBLE_MODE_EN
      r_byte   <= 8'h00;
      r_lo     <= 1'b0;
      r_single <= 1'b0;
`endif
    end else if (w_launch) begin
      r_main   <= w_nxt_main;
      r_idx    <= w_nxt_idx;
      r_col    <= w_nxt_col;
      r_line   <= w_nxt_line;
      r_ready  <= w_nxt_ready;
      r_rs     <= w_nxt_rs;
      r_is_clr <= !w_nxt_rs && (w_nxt_byte == CLEAR);
      r_bst    <= B_SETUP;
      r_cnt    <= '0;
`ifdef LCD_NIBBLE_MODE_EN
      r_byte   <= w_nxt_byte;
      r_lo     <= 1'b0;
      r_single <= w_nxt_single;
      r_d      <= {w_nxt_byte[7:4], 4'h0};
`else
      r_d      <= w_nxt_byte;
`endif
    end else begin
      case (r_bst)
        B_SETUP: begin
          if (w_en_done) begin
            r_bst <= B_PULSE;
            r_e   <= 1'b1;
            r_cnt <= '0;
          end else r_cnt <= r_cnt + 1'b1;
        end
        B_PULSE: begin
          if (w_en_done) begin
            r_bst <= B_HOLD;
            r_e   <= 1'b0;
            r_cnt <= '0;
          end else r_cnt <= r_cnt + 1'b1;
        end
        B_HOLD: begin
          if (w_en_done) begin
            r_cnt <= '0;
`ifdef LCD_NIBBLE_MODE_EN
            // Low nibble follows immediately; WAIT only after the full byte
            if (!r_lo && !r_single) begin
              r_lo  <= 1'b1;
              r_d   <= {r_byte[3:0], 4'h0};
              r_bst <= B_SETUP;
            end else begin
              r_bst <= B_WAIT;
            end
`else
            r_bst <= B_WAIT;
`endif
          end else r_cnt <= r_cnt + 1'b1;
        end
        default: r_cnt <= r_cnt + 1'b1;  // IDLE and WAIT just count to w_launch
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
`timescale 1ns/1ps
module tb_lcd_text_ctrl;

  localparam int COLS  = 20;
  localparam int LINES = 2;
  localparam int EN    = 2;
  localparam int CMDW  = 4;
  localparam int CLRW  = 8;
  localparam int PWR   = 64;
  localparam int N     = LINES * COLS;
  localparam int AW    = $clog2(N);
`ifdef LCD_NIBBLE_MODE_EN
  localparam bit NIB = 1'b1;
`else
  localparam bit NIB = 1'b0;
`endif
  localparam int K = NIB ? 2 : 1;  // bus transfers per byte

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         gap;   // clocks from this E fall to the next E rise
    logic       rdy;
  } xfer_t;

  logic          FPGA_CLK = 1'b0;
  logic          RST;
  logic          WR_EN;
  logic [AW-1:0] WR_ADDR;
  logic [7:0]    WR_DATA;
  logic          READY;
  logic          LCD_RS;
  logic          LCD_RW;
  logic          LCD_E;
  logic [7:0]    LCD_D;

  xfer_t      exp_q[$];
  logic [7:0] model [N];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  lcd_text_ctrl #(
    .COLS(COLS), .LINES(LINES), .ENABLE_CYC(EN), .CMD_WAIT_CYC(CMDW),
    .CLR_WAIT_CYC(CLRW), .PWRUP_WAIT_CYC(PWR)
  ) dut (
    .FPGA_CLK (FPGA_CLK),
    .RST      (RST),
    .WR_EN    (WR_EN),
    .WR_ADDR  (WR_ADDR),
    .WR_DATA  (WR_DATA),
    .READY    (READY),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_E    (LCD_E),
    .LCD_D    (LCD_D)
  );

  always #10 FPGA_CLK = ~FPGA_CLK;

  always @(posedge FPGA_CLK) cyc <= RST ? 0 : cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One byte (or lone nibble) as the panel should see it
  task automatic push_xfer(input logic rs, input logic [7:0] b, input logic rdy, input logic single);
    int w;
    w = (!rs && b == 8'h01) ? CLRW : CMDW;
    if (!NIB) begin
      exp_q.push_back('{rs, b, 2*EN + w, rdy});
    end else if (single) begin
      exp_q.push_back('{rs, {b[7:4], 4'h0}, 2*EN + w, rdy});
    end else begin
      exp_q.push_back('{rs, {b[7:4], 4'h0}, 2*EN, rdy});
      exp_q.push_back('{rs, {b[3:0], 4'h0}, 2*EN + w, rdy});
    end
  endtask

  task automatic push_init();
    if (NIB) begin
      push_xfer(1'b0, 8'h30, 1'b0, 1'b1);
      push_xfer(1'b0, 8'h30, 1'b0, 1'b1);
      push_xfer(1'b0, 8'h30, 1'b0, 1'b1);
      push_xfer(1'b0, 8'h20, 1'b0, 1'b1);
      push_xfer(1'b0, 8'h28, 1'b0, 1'b0);
    end else begin
      push_xfer(1'b0, 8'h38, 1'b0, 1'b0);
    end
    push_xfer(1'b0, 8'h0C, 1'b0, 1'b0);
    push_xfer(1'b0, 8'h06, 1'b0, 1'b0);
    push_xfer(1'b0, 8'h01, 1'b0, 1'b0);
  endtask

  task automatic push_pass();
    for (int ln = 0; ln < LINES; ln++) begin
      push_xfer(1'b0, (ln != 0) ? 8'hC0 : 8'h80, 1'b1, 1'b0);
      for (int c = 0; c < COLS; c++) push_xfer(1'b1, model[ln*COLS + c], 1'b1, 1'b0);
    end
  endtask

  task automatic wr(input int addr, input logic [7:0] data);
    WR_EN   = 1'b1;
    WR_ADDR = AW'(addr);
    WR_DATA = data;
    @(posedge FPGA_CLK); #1;
    WR_EN   = 1'b0;
  endtask

  task automatic wait_q(input int n, input string tag);
    for (int i = 0; i < 20000; i++) begin
      if (exp_q.size() <= n) break;
      @(posedge FPGA_CLK); #1;
    end
    check(tag, 32'(exp_q.size() <= n), 32'd1);
  endtask

  // Bus monitor: pops one expectation per E rise, checks pulse width, gaps and hold
  logic       prev_e   = 1'b0;
  bit         first    = 1'b1;
  int         hi_cnt   = 0;
  int         last_fall = 0;
  int         prev_gap = 0;
  logic [7:0] cur_d    = 8'h00;
  logic       cur_rs   = 1'b0;
  xfer_t      cur;

  always @(negedge FPGA_CLK) begin
    if (RST) begin
      first  = 1'b1;
    end else if (LCD_E && !prev_e) begin
      hi_cnt = 1;
      if (first) check("first_e_rise_cycle", 32'(cyc), 32'(PWR + EN));
      else       check("e_low_gap", 32'(cyc - last_fall), 32'(prev_gap));
      first = 1'b0;
      check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        check("lcd_rs", 32'(LCD_RS), 32'(cur.rs));
        check("lcd_d", 32'(LCD_D), 32'(cur.d));
        check("ready_at_xfer", 32'(READY), 32'(cur.rdy));
        check("lcd_rw", 32'(LCD_RW), 32'd0);
        prev_gap = cur.gap;
        cur_d    = cur.d;
        cur_rs   = cur.rs;
      end
    end else if (LCD_E) begin
      hi_cnt++;
    end else if (prev_e) begin
      check("e_high_width", 32'(hi_cnt), 32'(EN));
      check("d_held_at_fall", 32'(LCD_D), 32'(cur_d));
      check("rs_held_at_fall", 32'(LCD_RS), 32'(cur_rs));
      last_fall = cyc;
    end
    prev_e = LCD_E;
  end

  initial begin
    RST = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = 8'h00;
    for (int i = 0; i < N; i++) model[i] = 8'h20;
    repeat (3) @(posedge FPGA_CLK); #1;
    check("rst_ready", 32'(READY), 32'd0);
    check("rst_rs", 32'(LCD_RS), 32'd0);
    check("rst_rw", 32'(LCD_RW), 32'd0);
    check("rst_e", 32'(LCD_E), 32'd0);
    check("rst_d", 32'(LCD_D), 32'd0);
    push_init();
    push_pass();
    push_pass();
    RST = 1'b0;

    // Write while still powering up (buffer sweep already done): must be dropped
    repeat (50) @(posedge FPGA_CLK); #1;
    wr(3, 8'h41);

    for (int i = 0; i < 2000; i++) begin
      if (READY) break;
      @(posedge FPGA_CLK); #1;
    end
    check("ready_rises", 32'(READY), 32'd1);
    wr(40, 8'h5A);   // out of range
    wr(63, 8'h5B);   // out of range

    // Second pass, line 1 past column 5: addresses 0 and COLS+1 already read this pass
    wait_q(14 * K, "reach_pass1_line1_col5");
    wr(0, 8'h48);          // 'H'
    wr(COLS + 1, 8'h69);   // 'i'
    model[0]        = 8'h48;
    model[COLS + 1] = 8'h69;
    push_pass();
    push_pass();

    // Reset in the middle of a pulse during the last queued pass
    wait_q(30 * K, "reach_pass3");
    for (int i = 0; i < 200; i++) begin
      if (LCD_E) break;
      @(posedge FPGA_CLK); #1;
    end
    check("e_high_before_rst", 32'(LCD_E), 32'd1);
    RST = 1'b1;
    @(posedge FPGA_CLK); #1;
    check("e_drop_on_rst", 32'(LCD_E), 32'd0);
    check("ready_drop_on_rst", 32'(READY), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge FPGA_CLK); #1;
    for (int i = 0; i < N; i++) model[i] = 8'h20;
    push_init();
    push_pass();
    RST = 1'b0;

    wait_q(0, "drain_after_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_text_ctrl.md
Name: lcd_text_ctrl

Overview:
- Parametrised HD44780-compatible character-LCD controller, successor to the fixed-string LCD1602 driver.
- Holds a LINES×COLS text buffer that user logic writes through a simple write port.
- Runs power-up wait and init, then refreshes the whole display continuously with cycle-exact E/RS/data timing derived from FPGA_CLK.
- Sits between application logic and the board LCD header.

Parameters:
- COLS, 16, characters per line (1–40).
- LINES, 2, display lines (1 or 2; line 1 DDRAM base 0x40).
- ENABLE_CYC, 25, E-high width and data setup/hold width in clocks (500 ns @ 50 MHz).
- CMD_WAIT_CYC, 2500, post-byte wait in clocks (50 µs).
- CLR_WAIT_CYC, 100000, post-clear (0x01) wait in clocks (2 ms).
- PWRUP_WAIT_CYC, 2000000, wait after reset before the first command (40 ms).

Ports:
- FPGA_CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- WR_EN  in  1  buffer write strobe.
- WR_ADDR  in  $clog2(LINES*COLS)  character index = line*COLS + col.
- WR_DATA  in  8  ASCII/CGROM code.
- READY  out  1  high once init is complete; writes are accepted only while READY=1.
- LCD_RS  out  1  register select (0 = command, 1 = data).
- LCD_RW  out  1  tied 0 (write only).
- LCD_E  out  1  enable strobe.
- LCD_D  out  8  data bus.

Behaviour:
- Reset values: READY=0, LCD_RS=0, LCD_RW=0, LCD_E=0, LCD_D=0x00, FSM=PWRUP, all counters 0.
- Buffer clear: during PWRUP a sweep writes 0x20 to every buffer entry, one per clock. The sweep finishes long before PWRUP_WAIT_CYC expires.
- Main FSM: PWRUP → INIT → LINE_SEL → CHAR → (next line: LINE_SEL | last line: LINE_SEL of line 0). Refresh loops forever.
- INIT sequence: 0x38, 0x0C, 0x06, 0x01, all with RS=0. READY rises the clock after the 0x01 wait ends.
- LINE_SEL sends the command 0x80 | (line ? 0x40 : 0x00).
- CHAR sends COLS data bytes (RS=1) read from the buffer.
- Byte-transfer sub-FSM:
  - SETUP: RS/D stable, E=0, for ENABLE_CYC clocks.
  - PULSE: E=1 for ENABLE_CYC clocks.
  - HOLD: E=0, RS/D held, for ENABLE_CYC clocks.
  - WAIT: CLR_WAIT_CYC clocks if the byte was command 0x01, else CMD_WAIT_CYC.
  - RS and D change only in SETUP.
- Buffer reads are registered (1-clock latency) and are issued during the previous byte's WAIT.
- Write rules:
  - WR_EN with READY=0 is ignored.
  - WR_ADDR ≥ LINES*COLS is ignored.
  - A write to the entry being read in the same clock returns old data; the new value appears on the next pass.
- RST asserted mid-transfer: E drops to 0 the next clock, the FSM returns to PWRUP and the buffer is re-cleared.
- All counters are wide enough for the largest wait; no wrap during a wait.

Optional Feature:
- Macro: LCD_NIBBLE_MODE_EN.
- Defined: 4-bit bus.
  - Init starts with nibbles 0x3, 0x3, 0x3, 0x2 (RS=0, each followed by CMD_WAIT_CYC), then 0x28 replaces 0x38.
  - Each byte is sent high nibble then low nibble on LCD_D[7:4]. Each nibble gets a full SETUP/PULSE/HOLD; WAIT applies after the low nibble only.
  - LCD_D[3:0] is held at 0.
- Undefined: 8-bit behaviour as above.

Decomposition:
- Package lcd_pkg:
  - HD44780 command constants: FUNC_SET_8B=0x38, FUNC_SET_4B=0x28, DISP_ON=0x0C, ENTRY_INC=0x06, CLEAR=0x01, SET_DDRAM=0x80, LINE1_BASE=0x40.
  - Main-FSM and byte-FSM state enums.
- Sub-module lcd_text_buf: LINES*COLS×8 simple dual-port RAM with sync write, registered read, and clear-sweep input.

Test Plan (sim params ENABLE_CYC=2, CMD_WAIT_CYC=4, CLR_WAIT_CYC=8, PWRUP_WAIT_CYC=64):
- Reset then run → first E rise after ≥64+2 clocks; bytes 0x38, 0x0C, 0x06, 0x01 with RS=0; E high exactly 2 clocks each; 8-clock gap after 0x01 → READY=1.
- No writes → first refresh sends 0x80, then 16 data bytes 0x20, then 0xC0, then 16×0x20; loop repeats.
- After READY, write addr 0='H', addr 17='i' → next pass shows 'H' as the first byte after 0x80 and 'i' as the second byte after 0xC0.
- WR_EN during PWRUP (addr 3=0x41), and write to addr 40 → both ignored; all bytes remain 0x20.
- RST pulse while E=1 mid-refresh → LCD_E=0 next clock, READY=0, full init sequence repeats, buffer back to 0x20.
- LCD_NIBBLE_MODE_EN defined → init nibbles 3, 3, 3, 2, then 0x2/0x8 pair; data 'A' seen as 0x4 then 0x1 on LCD_D[7:4], with LCD_D[3:0]=0.
